// File: rtl/mux4_ser_sequencer.sv
// rtl/mux4_ser_sequencer.sv - 4-bit parallel-to-serial sequencer driving a 4-to-1 mux select (optional macro: MSB_FIRST_EN)
module mux4_ser_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       ser_ready,
    output logic [1:0] sel,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy
);

    localparam int CW = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

`ifdef MSB_FIRST_EN
    localparam logic [1:0] SEL_START = 2'd3;
    localparam logic [1:0] SEL_LAST  = 2'd0;
`else
    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_LAST  = 2'd3;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    data_q, data_nxt;
    logic [1:0]    sel_q, sel_nxt, sel_step;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic          bit_done;
    logic          word_done;
    logic          accept;

    // Bit-cycle completion and the handshake that can reload in the final bit-cycle
    always_comb begin
        bit_done  = (state == SHIFT) && ser_ready && (hold_cnt == HOLD_LAST);
        word_done = bit_done && (sel_q == SEL_LAST);
        in_ready  = (state == IDLE) || word_done;
        accept    = in_valid && in_ready;
`ifdef MSB_FIRST_EN
        sel_step  = sel_q - 2'd1;
`else
        sel_step  = sel_q + 2'd1;
`endif
    end

    // Serial outputs are derived from state so reset clears them without a clock edge
    always_comb begin
        ser_valid = (state == SHIFT);
        busy      = (state == SHIFT);
        sel       = sel_q;
        ser_out   = (state == SHIFT) ? data_q[sel_q] : 1'b0;
        ser_last  = (state == SHIFT) && (sel_q == SEL_LAST);
    end

    // Next-state logic: capture, hold counting, select stepping and reload/return-to-idle
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        sel_nxt   = sel_q;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    data_nxt  = in_data;
                    sel_nxt   = SEL_START;
                    hold_nxt  = '0;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_nxt = hold_cnt + CW'(1);
                    end else if (sel_q != SEL_LAST) begin
                        sel_nxt  = sel_step;
                        hold_nxt = '0;
                    end else if (accept) begin
                        // Reload wins over returning to idle for gap-free streaming
                        data_nxt = in_data;
                        sel_nxt  = SEL_START;
                        hold_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        sel_nxt   = 2'd0;
                        hold_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 2'd0;
                hold_nxt  = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_q   <= 4'd0;
            sel_q    <= 2'd0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            data_q   <= data_nxt;
            sel_q    <= sel_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_mux4_ser_sequencer.sv
// tb/tb_mux4_ser_sequencer.sv - randomized bench for mux4_ser_sequencer with a bit-cycle queue model
module tb_mux4_ser_sequencer;

    localparam int HOLD0 = 1;
    localparam int HOLD1 = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv [2];
    logic [3:0] id [2];
    logic       sr [2];
    logic       ir [2];
    logic [1:0] sl [2];
    logic       so [2];
    logic       sv [2];
    logic       slast [2];
    logic       bz [2];

    always #5 clk = ~clk;

    mux4_ser_sequencer #(.HOLD_CYCLES(HOLD0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .ser_ready(sr[0]), .sel(sl[0]), .ser_out(so[0]), .ser_valid(sv[0]),
        .ser_last(slast[0]), .busy(bz[0])
    );

    mux4_ser_sequencer #(.HOLD_CYCLES(HOLD1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .ser_ready(sr[1]), .sel(sl[1]), .ser_out(so[1]), .ser_valid(sv[1]),
        .ser_last(slast[1]), .busy(bz[1])
    );

    // One entry per bit-cycle the DUT must present; popped on every ser_ready=1 cycle
    typedef struct packed {
        logic [1:0] s;
        logic       b;
        logic       l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    tests = 0;
    int    fails = 0;
    logic  acc [2];

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qhead(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qclear();
        q0.delete();
        q1.delete();
    endtask

    // A word becomes four bit positions in transmit order, each repeated HOLD times
    task automatic qpush_word(input int i, input logic [3:0] w);
        int    hold;
        int    idx;
        beat_t e;
        hold = (i == 0) ? HOLD0 : HOLD1;
        for (int k = 0; k < 4; k++) begin
`ifdef MSB_FIRST_EN
            idx = 3 - k;
`else
            idx = k;
`endif
            for (int h = 0; h < hold; h++) begin
                e.s = 2'(idx);
                e.b = w[idx];
                e.l = (k == 3);
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // Called right after inputs are set at a negedge; checks, advances the model, ends at next negedge
    task automatic cycle();
        beat_t h;
        logic  ev;
        logic  er;
        #1;
        for (int i = 0; i < 2; i++) begin
            ev = (qsize(i) > 0);
            h  = ev ? qhead(i) : '0;
            er = !ev || (qsize(i) == 1 && sr[i]);
            check($sformatf("u%0d ser_valid", i), {3'b0, sv[i]}, {3'b0, ev});
            check($sformatf("u%0d busy", i), {3'b0, bz[i]}, {3'b0, ev});
            check($sformatf("u%0d sel", i), {2'b0, sl[i]}, {2'b0, h.s});
            check($sformatf("u%0d ser_out", i), {3'b0, so[i]}, {3'b0, h.b});
            check($sformatf("u%0d ser_last", i), {3'b0, slast[i]}, {3'b0, h.l});
            check($sformatf("u%0d in_ready", i), {3'b0, ir[i]}, {3'b0, er});
            acc[i] = iv[i] && er;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (qsize(i) > 0 && sr[i]) qpop(i);
            if (acc[i]) qpush_word(i, id[i]);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic r);
        for (int i = 0; i < 2; i++) begin
            iv[i] = v;
            id[i] = d;
            sr[i] = r;
        end
    endtask

    initial begin
        drive(1'b0, 4'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d rst ser_valid", i), {3'b0, sv[i]}, 4'd0);
            check($sformatf("u%0d rst in_ready", i), {3'b0, ir[i]}, 4'd1);
            check($sformatf("u%0d rst sel", i), {2'b0, sl[i]}, 4'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single word 1010
        drive(1'b1, 4'b1010, 1'b1);
        cycle();
        drive(1'b0, 4'b0000, 1'b1);
        repeat (14) cycle();

        // Back-to-back 1100 then 0011 with in_valid held high
        drive(1'b1, 4'b1100, 1'b1);
        for (int n = 0; n < 40; n++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (acc[i] && id[i] == 4'b1100) id[i] = 4'b0011;
                else if (acc[i]) iv[i] = 1'b0;
            end
        end

        // Word 0110 with a 3-cycle stall in the middle of the word
        drive(1'b1, 4'b0110, 1'b1);
        cycle();
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        repeat (2) cycle();
        drive(1'b0, 4'b0000, 1'b0);
        repeat (3) cycle();
        drive(1'b0, 4'b0000, 1'b1);
        repeat (12) cycle();

        // Asynchronous reset mid-word
        drive(1'b1, 4'b1111, 1'b1);
        cycle();
        drive(1'b0, 4'b0000, 1'b1);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        qclear();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d abort ser_valid", i), {3'b0, sv[i]}, 4'd0);
            check($sformatf("u%0d abort busy", i), {3'b0, bz[i]}, 4'd0);
            check($sformatf("u%0d abort sel", i), {2'b0, sl[i]}, 4'd0);
            check($sformatf("u%0d abort in_ready", i), {3'b0, ir[i]}, 4'd1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, 1'b1);
        cycle();
        drive(1'b0, 4'b0000, 1'b1);
        repeat (12) cycle();

        // Randomized traffic with random stalls
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                iv[i] = ($urandom_range(0, 3) != 0);
                id[i] = 4'($urandom_range(0, 15));
                sr[i] = ($urandom_range(0, 4) != 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
